wb_fwd_pipe: RTL and testbench
==============================

# wb_fwd_pipe

Parametrised write-back pipeline for the openmips core: carries the EX result record {wreg, wd, wdata, pend} through `STAGES` register stages to the regfile write port. Replaces the fixed ex_mem / mem / mem_wb chain. Adds per-stage stall with bubble insertion, global flush, load-data resolution at a configurable stage, and `RD_PORTS` forwarding read ports with hazard detection. Sits between EX and regfile, and serves ID's operand reads.

## Interface
Parameters:
- `DATA_W`, 32, data width.
- `ADDR_W`, 5, register address width.
- `STAGES`, 3, register stages, ≥2; stage 0 youngest, stage STAGES-1 drives the write port.
- `RD_PORTS`, 2, forwarding read ports.
- `LOAD_STAGE`, 1, stage whose outgoing entry is resolved with load data; 0 ≤ LOAD_STAGE ≤ STAGES-2.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_wreg` in 1: EX record write enable.
- `in_wd` in ADDR_W: EX destination register.
- `in_wdata` in DATA_W: EX result.
- `in_pend` in 1: result is a load; value not yet known.
- `ready_o` out 1: stage 0 accepts `in_*` this cycle.
- `stall_i` in STAGES: per-stage stall request.
- `flush_i` in 1: discard all in-flight entries.
- `ld_data_i` in DATA_W: load data for the entry leaving LOAD_STAGE.
- `we_o` out 1: regfile write enable.
- `waddr_o` out ADDR_W: regfile write address.
- `wdata_o` out DATA_W: regfile write data.
- `raddr_i` in RD_PORTS*ADDR_W: read addresses, port r at [r*ADDR_W +: ADDR_W].
- `rf_data_i` in RD_PORTS*DATA_W: regfile read data per port.
- `rdata_o` out RD_PORTS*DATA_W: forwarded operand per port.
- `hazard_o` out RD_PORTS: operand depends on a pending load.

## Operation
- Hold: h[k] = OR of stall_i[STAGES-1:k]. A later stage's stall holds all earlier stages.
- Stage k with h[k]=1 keeps its contents.
- Stage k≥1 with h[k]=0, h[k-1]=1 captures a bubble: wreg=0, pend=0, wd=0, wdata=0.
- Stage k≥1 with h[k]=0, h[k-1]=0 captures stage k-1.
- Stage 0 with h[0]=0 captures `in_*`.
- `ready_o` = ~h[0], combinational. The record on `in_*` is lost if `ready_o`=0; EX holds it.
- Load resolve: when stage LOAD_STAGE advances into LOAD_STAGE+1 with pend=1, stage LOAD_STAGE+1 captures wdata=`ld_data_i`, pend=0.
- An entry with pend=1 never reaches the last stage; an entry arriving there with pend=1 is a design error, flagged by an assertion.
- Flush: `flush_i`=1 loads a bubble into every stage at the next edge. Flush overrides stall and capture.
- Write port: `we_o`/`waddr_o`/`wdata_o` = last stage {wreg, wd, wdata}, registered only.
- Forwarding, per port r:
  - Candidates, youngest first: `in_*` (only when `in_wreg`), then stage 0 … STAGES-1.
  - Hit: wreg=1 and wd == raddr and raddr ≠ 0.
  - `rdata_o[r]` = youngest hit's wdata; on no hit, `rf_data_i[r]`.
  - `hazard_o[r]` = youngest hit has pend=1; `rdata_o[r]` is then don't-care.
  - Address 0 never hits and never hazards.
- Only the youngest hit is used; an older matching entry is ignored.

## Timing
- Reset (rst=0, asynchronous): all stages bubble. `we_o`=0, `waddr_o`=0, `wdata_o`=0.
- Combinational outputs during reset: `rdata_o`=`rf_data_i` unless `in_*` hits; `hazard_o` follows `in_pend` hits; `ready_o`=~h[0].
- Reset assertion mid-stream drops all entries at once. No write occurs in the reset cycle.
- Latency, no stalls: a record accepted at edge n appears on `we_o` after edge n+STAGES-1 and is visible to forwarding from the same cycle it is offered.
- Throughput: one record per cycle.
- Forwarding and `hazard_o`: pure combinational, same cycle.
- `flush_i` together with `stall_i`: flush wins, all stages become bubbles.
- Stall on the last stage holds `we_o` high for repeated cycles; the regfile rewrites the same value, which is harmless.

## Structure
- Shared package `pipe_pkg`:
  - record field offsets and `REC_W` = 2+ADDR_W+DATA_W;
  - `BUBBLE` constant;
  - `REG_ZERO` address constant.
- One sub-module, `pipe_slot`: one stage register with hold / bubble / capture / flush select and async active-low reset. Instantiated STAGES times in a generate loop.
- Forwarding comparators: generate loop over ports, priority-encoded youngest-first.

## Test plan
- Straight flow, STAGES=3: offer {1, r5, 0x1234, 0} at edge 0 → `we_o`=1, `waddr_o`=5, `wdata_o`=0x1234 after edge 2. Raddr=5 returns 0x1234 in every cycle from offer to write.
- Priority: stage 1 holds r7=0xAAAA, stage 0 holds r7=0xBBBB → `rdata_o`=0xBBBB. Raddr=0 with an in-flight r0 write → `rf_data_i`.
- Stall: stall_i=3'b010 for 2 cycles → stages 0–1 hold, stage 2 receives bubbles (`we_o`=0 while stage 2 holds a bubble), `ready_o`=0. Flow resumes with no loss or duplication.
- Load: offer {1, r3, x, pend=1} with LOAD_STAGE=1 → `hazard_o`=1 for raddr=3 while the entry is in stages ≤1. Entry leaves stage 1 with `ld_data_i`=0xDEAD → `rdata_o`=0xDEAD, `hazard_o`=0, and `wdata_o`=0xDEAD on write.
- Flush with stall_i all ones and three valid entries → next cycle all stages bubble, `we_o`=0, no forwarding hits.
- Async reset asserted between edges with entries in flight → `we_o`/`waddr_o`/`wdata_o`=0 immediately. After release, the first write is the first record offered after reset.

Source files
------------

// File: rtl/pipe_pkg.sv
// Record layout shared by the write-back pipe: {wreg, pend, wd, wdata}, wdata in the LSBs.
// Widths are parametric, so offsets come from constant functions.
package pipe_pkg;

  localparam int MAX_REC_W = 1024;
  localparam logic [MAX_REC_W-1:0] BUBBLE = '0;
  localparam logic [31:0] REG_ZERO = '0;

  function automatic int rec_w(input int addr_w, input int data_w);
    return 2 + addr_w + data_w;
  endfunction

  function automatic int off_wd(input int data_w);
    return data_w;
  endfunction

  function automatic int off_pend(input int addr_w, input int data_w);
    return data_w + addr_w;
  endfunction

  function automatic int off_wreg(input int addr_w, input int data_w);
    return data_w + addr_w + 1;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipe stage register: flush > hold > bubble > capture, async active-low reset to a bubble.
// One-cycle latency; hold keeps contents, which is how stalls push back on upstream stages.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int W = 39
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         hold,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= BUBBLE[W-1:0];
    end else if (flush) begin
      q <= BUBBLE[W-1:0];
    end else if (!hold) begin
      if (bubble) q <= BUBBLE[W-1:0];
      else        q <= d;
    end
  end

endmodule

// File: rtl/wb_fwd_pipe.sv
// Write-back pipe: EX record reaches the regfile write port STAGES-1 edges after acceptance; operands forwarded youngest-first.
// Stalls hold a stage and all younger ones, older stages take bubbles; ready_o drops while stage 0 is held.
module wb_fwd_pipe
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STAGES     = 3,
  parameter int RD_PORTS   = 2,
  parameter int LOAD_STAGE = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_wreg,
  input  logic [ADDR_W-1:0]            in_wd,
  input  logic [DATA_W-1:0]            in_wdata,
  input  logic                         in_pend,
  output logic                         ready_o,
  input  logic [STAGES-1:0]            stall_i,
  input  logic                         flush_i,
  input  logic [DATA_W-1:0]            ld_data_i,
  output logic                         we_o,
  output logic [ADDR_W-1:0]            waddr_o,
  output logic [DATA_W-1:0]            wdata_o,
  input  logic [RD_PORTS*ADDR_W-1:0]   raddr_i,
  input  logic [RD_PORTS*DATA_W-1:0]   rf_data_i,
  output logic [RD_PORTS*DATA_W-1:0]   rdata_o,
  output logic [RD_PORTS-1:0]          hazard_o
);

  localparam int REC_W  = rec_w(ADDR_W, DATA_W);
  localparam int O_WD   = off_wd(DATA_W);
  localparam int O_PEND = off_pend(ADDR_W, DATA_W);
  localparam int O_WREG = off_wreg(ADDR_W, DATA_W);

  logic [STAGES-1:0][REC_W-1:0] q;
  logic [STAGES-1:0][REC_W-1:0] d;
  logic [STAGES-1:0]            h;
  logic [STAGES-1:0]            bub;
  logic [REC_W-1:0]             in_rec;
  logic [REC_W-1:0]             ld_src;
  logic [REC_W-1:0]             ld_rec;

  // A stall at stage k also freezes every younger stage.
  always_comb begin
    logic acc;
    acc = 1'b0;
    h   = '0;
    for (int k = STAGES-1; k >= 0; k--) begin
      acc  = acc | stall_i[k];
      h[k] = acc;
    end
  end

  assign ready_o = ~h[0];
  assign bub     = {h[STAGES-2:0], 1'b0};
  assign in_rec  = {in_wreg, in_pend, in_wd, in_wdata};

  // The entry crossing LOAD_STAGE -> LOAD_STAGE+1 picks up the load data if still pending.
  assign ld_src = q[LOAD_STAGE];
  assign ld_rec = ld_src[O_PEND] ? {ld_src[O_WREG], 1'b0, ld_src[O_WD +: ADDR_W], ld_data_i}
                                 : ld_src;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign d[k] = in_rec;
    end else if (k == LOAD_STAGE + 1) begin : g_load
      assign d[k] = ld_rec;
    end else begin : g_mid
      assign d[k] = q[k-1];
    end

    pipe_slot #(.W(REC_W)) u_slot (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush_i),
      .hold   (h[k]),
      .bubble (bub[k]),
      .d      (d[k]),
      .q      (q[k])
    );
  end

  assign we_o    = q[STAGES-1][O_WREG];
  assign waddr_o = q[STAGES-1][O_WD +: ADDR_W];
  assign wdata_o = q[STAGES-1][DATA_W-1:0];

  for (genvar r = 0; r < RD_PORTS; r++) begin : g_port
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] dat;
    logic              haz;

    assign ra = raddr_i[r*ADDR_W +: ADDR_W];

    // Walk oldest to youngest so the youngest hit overwrites older ones.
    always_comb begin
      dat = rf_data_i[r*DATA_W +: DATA_W];
      haz = 1'b0;
      if (ra != REG_ZERO[ADDR_W-1:0]) begin
        for (int j = STAGES-1; j >= 0; j--) begin
          if (q[j][O_WREG] && (q[j][O_WD +: ADDR_W] == ra)) begin
            dat = q[j][DATA_W-1:0];
            haz = q[j][O_PEND];
          end
        end
        if (in_wreg && (in_wd == ra)) begin
          dat = in_wdata;
          haz = in_pend;
        end
      end
    end

    assign rdata_o[r*DATA_W +: DATA_W] = dat;
    assign hazard_o[r]                 = haz;
  end

  a_no_pend_at_write: assert property (@(posedge clk) disable iff (!rst) !q[STAGES-1][O_PEND]);

endmodule

// File: tb/tb_wb_fwd_pipe.sv
// Directed bench for wb_fwd_pipe (STAGES=3, LOAD_STAGE=1, RD_PORTS=2): vector table plus reset sequence.
module tb_wb_fwd_pipe;

  logic        clk;
  logic        rst;
  logic        in_wreg;
  logic [4:0]  in_wd;
  logic [31:0] in_wdata;
  logic        in_pend;
  logic        ready_o;
  logic [2:0]  stall_i;
  logic        flush_i;
  logic [31:0] ld_data_i;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic [9:0]  raddr_i;
  logic [63:0] rf_data_i;
  logic [63:0] rdata_o;
  logic [1:0]  hazard_o;

  int n_chk;
  int n_fail;

  wb_fwd_pipe #(
    .DATA_W(32), .ADDR_W(5), .STAGES(3), .RD_PORTS(2), .LOAD_STAGE(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_wreg   (in_wreg),
    .in_wd     (in_wd),
    .in_wdata  (in_wdata),
    .in_pend   (in_pend),
    .ready_o   (ready_o),
    .stall_i   (stall_i),
    .flush_i   (flush_i),
    .ld_data_i (ld_data_i),
    .we_o      (we_o),
    .waddr_o   (waddr_o),
    .wdata_o   (wdata_o),
    .raddr_i   (raddr_i),
    .rf_data_i (rf_data_i),
    .rdata_o   (rdata_o),
    .hazard_o  (hazard_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        pend;
    logic [2:0]  stall;
    logic        flush;
    logic [31:0] ld;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        rd_dc;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_rdy;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_haz;
  } vec_t;

  localparam int NV = 22;
  vec_t vec [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] v, input logic p);
    in_wreg  = w;
    in_wd    = a;
    in_wdata = v;
    in_pend  = p;
  endtask

  initial begin
    logic found;
    n_chk  = 0;
    n_fail = 0;

    // wreg wd wdata pend stall flush ld ra0 ra1 dc | we waddr wdata rdy rd0 rd1 haz
    vec[0]  = '{1, 5,  'h1234, 0, 3'b000, 0, 0,       5,  7,  0, 0, 0,  0,       1, 'h1234, 'hF001, 2'b00};
    vec[1]  = '{1, 7,  'hAAAA, 0, 3'b000, 0, 0,       5,  7,  0, 0, 0,  0,       1, 'h1234, 'hAAAA, 2'b00};
    vec[2]  = '{1, 7,  'hBBBB, 0, 3'b000, 0, 0,       5,  7,  0, 0, 0,  0,       1, 'h1234, 'hBBBB, 2'b00};
    vec[3]  = '{0, 7,  'h9999, 0, 3'b000, 0, 0,       5,  7,  0, 1, 5,  'h1234,  1, 'h1234, 'hBBBB, 2'b00};
    vec[4]  = '{1, 0,  'h5555, 0, 3'b000, 0, 0,       0,  7,  0, 1, 7,  'hAAAA,  1, 'hF000, 'hBBBB, 2'b00};
    vec[5]  = '{0, 0,  0,      0, 3'b000, 0, 0,       0,  7,  0, 1, 7,  'hBBBB,  1, 'hF000, 'hBBBB, 2'b00};
    vec[6]  = '{1, 9,  'h0901, 0, 3'b010, 0, 0,       9,  7,  0, 0, 7,  'h9999,  0, 'h0901, 'hF001, 2'b00};
    vec[7]  = '{1, 9,  'h0901, 0, 3'b010, 0, 0,       9,  7,  0, 0, 0,  0,       0, 'h0901, 'hF001, 2'b00};
    vec[8]  = '{1, 9,  'h0901, 0, 3'b000, 0, 0,       9,  7,  0, 0, 0,  0,       1, 'h0901, 'hF001, 2'b00};
    vec[9]  = '{1, 10, 'h0A0A, 0, 3'b000, 0, 0,       9,  7,  0, 1, 0,  'h5555,  1, 'h0901, 'hF001, 2'b00};
    vec[10] = '{0, 0,  0,      0, 3'b000, 0, 0,       9,  7,  0, 0, 0,  0,       1, 'h0901, 'hF001, 2'b00};
    vec[11] = '{0, 0,  0,      0, 3'b000, 0, 0,       9,  7,  0, 1, 9,  'h0901,  1, 'h0901, 'hF001, 2'b00};
    vec[12] = '{0, 0,  0,      0, 3'b000, 0, 0,       9,  7,  0, 1, 10, 'h0A0A,  1, 'hF000, 'hF001, 2'b00};
    vec[13] = '{1, 3,  0,      1, 3'b000, 0, 0,       3,  3,  1, 0, 0,  0,       1, 0,      0,      2'b11};
    vec[14] = '{0, 0,  0,      0, 3'b000, 0, 0,       3,  3,  1, 0, 0,  0,       1, 0,      0,      2'b11};
    vec[15] = '{0, 0,  0,      0, 3'b000, 0, 'hDEAD,  3,  3,  1, 0, 0,  0,       1, 0,      0,      2'b11};
    vec[16] = '{0, 0,  0,      0, 3'b000, 0, 0,       3,  3,  0, 1, 3,  'hDEAD,  1, 'hDEAD, 'hDEAD, 2'b00};
    vec[17] = '{1, 11, 'h1111, 0, 3'b000, 0, 0,       11, 12, 0, 0, 0,  0,       1, 'h1111, 'hF001, 2'b00};
    vec[18] = '{1, 12, 'h1212, 0, 3'b000, 0, 0,       11, 12, 0, 0, 0,  0,       1, 'h1111, 'h1212, 2'b00};
    vec[19] = '{1, 13, 'h1313, 0, 3'b000, 0, 0,       11, 12, 0, 0, 0,  0,       1, 'h1111, 'h1212, 2'b00};
    vec[20] = '{0, 0,  0,      0, 3'b111, 1, 0,       11, 13, 0, 1, 11, 'h1111,  0, 'h1111, 'h1313, 2'b00};
    vec[21] = '{0, 0,  0,      0, 3'b000, 0, 0,       11, 13, 0, 0, 0,  0,       1, 'hF000, 'hF001, 2'b00};

    rst       = 1'b0;
    drive(0, 0, 0, 0);
    stall_i   = '0;
    flush_i   = 1'b0;
    ld_data_i = '0;
    raddr_i   = '0;
    rf_data_i = {32'hF001, 32'hF000};

    #2;
    chk("reset we", {31'd0, we_o}, 0);
    chk("reset waddr", {27'd0, waddr_o}, 0);
    chk("reset wdata", wdata_o, 0);
    chk("reset ready", {31'd0, ready_o}, 1);

    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vec[i].wreg, vec[i].wd, vec[i].wdata, vec[i].pend);
      stall_i   = vec[i].stall;
      flush_i   = vec[i].flush;
      ld_data_i = vec[i].ld;
      raddr_i   = {vec[i].ra1, vec[i].ra0};
      #1;
      chk($sformatf("v%0d we", i), {31'd0, we_o}, {31'd0, vec[i].e_we});
      chk($sformatf("v%0d waddr", i), {27'd0, waddr_o}, {27'd0, vec[i].e_waddr});
      chk($sformatf("v%0d wdata", i), wdata_o, vec[i].e_wdata);
      chk($sformatf("v%0d ready", i), {31'd0, ready_o}, {31'd0, vec[i].e_rdy});
      chk($sformatf("v%0d hazard", i), {30'd0, hazard_o}, {30'd0, vec[i].e_haz});
      if (!vec[i].rd_dc) begin
        chk($sformatf("v%0d rdata0", i), rdata_o[31:0], vec[i].e_rd0);
        chk($sformatf("v%0d rdata1", i), rdata_o[63:32], vec[i].e_rd1);
      end
    end

    // Fill the pipe, then hit it with an asynchronous reset between edges.
    @(negedge clk); drive(1, 20, 32'h20, 0); stall_i = '0; flush_i = 1'b0; raddr_i = '0;
    @(negedge clk); drive(1, 21, 32'h21, 0);
    @(negedge clk); drive(1, 22, 32'h22, 0);
    @(negedge clk); drive(0, 0, 0, 0);
    #1;
    chk("pre-reset we", {31'd0, we_o}, 1);
    chk("pre-reset waddr", {27'd0, waddr_o}, 20);
    #2;
    rst = 1'b0;
    drive(1, 5, 32'h77, 0);
    raddr_i = {5'd21, 5'd5};
    #1;
    chk("async reset we", {31'd0, we_o}, 0);
    chk("async reset waddr", {27'd0, waddr_o}, 0);
    chk("async reset wdata", wdata_o, 0);
    chk("in-reset fwd in", rdata_o[31:0], 32'h77);
    chk("in-reset fwd dropped", rdata_o[63:32], 32'hF001);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 25, 32'h2525, 0);
    raddr_i = '0;
    @(negedge clk);
    drive(0, 0, 0, 0);
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      #1;
      if (we_o) found = 1'b1;
      else @(negedge clk);
    end
    chk("post-reset write seen", {31'd0, found}, 1);
    chk("post-reset first waddr", {27'd0, waddr_o}, 25);
    chk("post-reset first wdata", wdata_o, 32'h2525);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
